// File: rtl/map_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : map_port_arbiter
// Purpose  : Round-robin arbiter that serialises read-modify-write updates of
//            4-bit tile codes in a 30x40 maze map. Each 160-bit RAM word holds
//            one map row, and column c occupies bits [159-4c:156-4c].
//            Every accepted request reads its row, replaces one nibble and
//            writes the row back. It then pulses done together with the old
//            tile code.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLOCK_50   in   1          sole clock, rising edge
//   reset      in   1          asynchronous, active-low
//   req        in   NREQ       per-requester request level
//   req_row    in   NREQ*5     row per requester (slice i = [5i+4:5i])
//   req_col    in   NREQ*6     column per requester (slice i = [6i+5:6i])
//   req_val    in   NREQ*4     new tile code per requester
//   hold       in   1          blocks acceptance of a new transaction
//   gnt        out  NREQ       one-hot grant for RD..WR
//   done       out  NREQ       one-cycle completion pulse
//   rd_old     out  4          previous tile code, valid with done
//   err        out  1          rejected request (column >= 40), with done
//   ram_addr   out  5          map RAM port-B address (row)
//   ram_wdata  out  160        map RAM port-B write data
//   ram_wren   out  1          map RAM port-B write enable
//   ram_rdata  in   160        map RAM port-B read data
//   busy       out  1          high whenever the FSM is not idle
// ============================================================================
module map_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int RD_LAT = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*5-1:0]   req_row,
  input  logic [NREQ*6-1:0]   req_col,
  input  logic [NREQ*4-1:0]   req_val,
  input  logic                hold,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [3:0]          rd_old,
  output logic                err,
  output logic [4:0]          ram_addr,
  output logic [159:0]        ram_wdata,
  output logic                ram_wren,
  input  logic [159:0]        ram_rdata,
  output logic                busy
);

  localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_PW-1:0]   r_ptr;
  logic [c_CW-1:0]   r_cnt;
  logic [NREQ-1:0]   r_oh;
  logic [4:0]        r_row;
  logic [5:0]        r_col;
  logic [3:0]        r_val;
  logic [159:0]      r_word;

  logic              w_found;
  int                w_sel;
  logic [NREQ-1:0]   w_sel_oh;
  logic [4:0]        w_row;
  logic [5:0]        w_col;
  logic [3:0]        w_val;
  logic [c_PW-1:0]   w_ptr_nxt;
  logic [7:0]        w_lo;
  logic [159:0]      w_merged;
  logic [3:0]        w_old;

  // Round-robin pick: first requesting index at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_sel   = (int'(r_ptr) + k) % NREQ;
      end
    end
  end

  always_comb begin
    w_sel_oh        = '0;
    w_sel_oh[w_sel] = 1'b1;
  end

  assign w_row     = req_row[5*w_sel +: 5];
  assign w_col     = req_col[6*w_sel +: 6];
  assign w_val     = req_val[4*w_sel +: 4];
  assign w_ptr_nxt = c_PW'((w_sel + 1) % NREQ);

  // Column 0 sits in the most significant nibble of the row word.
  assign w_lo = 8'd156 - {r_col, 2'b00};

  always_comb begin
    w_merged          = ram_rdata;
    w_merged[w_lo +: 4] = r_val;
  end

  assign w_old = r_word[w_lo +: 4];

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_oh      <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_val     <= '0;
      r_word    <= '0;
      gnt       <= '0;
      done      <= '0;
      rd_old    <= '0;
      err       <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!hold && w_found) begin
            r_ptr <= w_ptr_nxt;
            r_oh  <= w_sel_oh;
            r_row <= w_row;
            r_col <= w_col;
            r_val <= w_val;
            busy  <= 1'b1;
            if (w_col <= 6'd39) begin
              r_state  <= S_RD;
              r_cnt    <= '0;
              gnt      <= w_sel_oh;
              ram_addr <= w_row;
            end else begin
              // Out-of-map column: skip the RAM entirely and report it.
              r_state <= S_DONE;
              done    <= w_sel_oh;
              err     <= 1'b1;
              rd_old  <= '0;
            end
          end
        end
        S_RD: begin
          if (r_cnt == c_LAST) begin
            // Last read cycle: capture the row and stage the merged write.
            r_word    <= ram_rdata;
            ram_wdata <= w_merged;
            ram_wren  <= 1'b1;
            r_state   <= S_WR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WR: begin
          ram_wren  <= 1'b0;
          ram_wdata <= '0;
          ram_addr  <= '0;
          gnt       <= '0;
          done      <= r_oh;
          rd_old    <= w_old;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          done    <= '0;
          err     <= 1'b0;
          rd_old  <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_map_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_port_arbiter
// Purpose  : Directed self-checking bench for map_port_arbiter with a
//            behavioural 32x160 map RAM (one-cycle registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_port_arbiter;

  localparam int NREQ = 3;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*5-1:0] req_row;
  logic [NREQ*6-1:0] req_col;
  logic [NREQ*4-1:0] req_val;
  logic              hold;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [3:0]        rd_old;
  logic              err;
  logic [4:0]        ram_addr;
  logic [159:0]      ram_wdata;
  logic              ram_wren;
  logic [159:0]      ram_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [159:0] mem [0:31];

  map_port_arbiter #(.NREQ(NREQ), .RD_LAT(2)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .req       (req),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_val   (req_val),
    .hold      (hold),
    .gnt       (gnt),
    .done      (done),
    .rd_old    (rd_old),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [5:0] c, input logic [3:0] v);
    req_row[5*i +: 5] = r;
    req_col[6*i +: 6] = c;
    req_val[4*i +: 4] = v;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"},   gnt, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_old"},   rd_old, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_wren"},  ram_wren, 0);
    chk({tag, "_addr"},  ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
  endtask

  logic [159:0] e;

  initial begin
    for (int r = 0; r < 32; r++) mem[r] = {160{1'b1}};
    mem[29]   = {40{4'h7}};
    ram_rdata = '0;
    reset     = 1'b0;
    req       = '0;
    req_row   = '0;
    req_col   = '0;
    req_val   = '0;
    hold      = 1'b0;

    // Reset state
    step(); step();
    chk_idle_outputs("rst");
    reset = 1'b1;
    step();
    chk_idle_outputs("post_rst");

    // Basic RMW: row 13, col 16, val 5 on requester 0
    set_req(0, 5'd13, 6'd16, 4'h5);
    req = 3'b001;
    step();                                  // cycle 1
    chk("t1_gnt_c1", gnt, 3'b001);
    chk("t1_busy_c1", busy, 1);
    chk("t1_wren_c1", ram_wren, 0);
    req = 3'b000;
    set_req(0, 5'd2, 6'd40, 4'hC);           // must not disturb the transaction
    step();                                  // cycle 2
    chk("t1_gnt_c2", gnt, 3'b001);
    chk("t1_addr_c2", ram_addr, 13);
    step();                                  // cycle 3
    e = {160{1'b1}};
    e[95:92] = 4'h5;
    chk("t1_wren_c3", ram_wren, 1);
    chk("t1_addr_c3", ram_addr, 13);
    chk("t1_wdata_c3", ram_wdata, e);
    chk("t1_gnt_c3", gnt, 3'b001);
    step();                                  // cycle 4
    chk("t1_done_c4", done, 3'b001);
    chk("t1_old_c4", rd_old, 4'hF);
    chk("t1_err_c4", err, 0);
    chk("t1_gnt_c4", gnt, 0);
    chk("t1_wren_c4", ram_wren, 0);
    chk("t1_mem13", mem[13], e);
    step();                                  // cycle 5
    chk_idle_outputs("t1_c5");

    // Rejected request: requester 1, col 40
    set_req(1, 5'd4, 6'd40, 4'h6);
    req = 3'b010;
    step();
    req = 3'b000;
    chk("t2_done", done, 3'b010);
    chk("t2_err", err, 1);
    chk("t2_old", rd_old, 0);
    chk("t2_wren", ram_wren, 0);
    chk("t2_gnt", gnt, 0);
    chk("t2_busy", busy, 1);
    step();
    chk_idle_outputs("t2_after");
    chk("t2_mem4", mem[4], {160{1'b1}});

    // hold blocks acceptance
    set_req(0, 5'd7, 6'd20, 4'h9);
    req  = 3'b001;
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_gnt", gnt, 0);
      chk("t3_hold_busy", busy, 0);
    end
    hold = 1'b0;
    step();                                  // cycle 1
    chk("t3_gnt", gnt, 3'b001);
    hold = 1'b1;                             // mid-transaction: must not abort
    step(); step();                          // cycle 3
    chk("t3_wren", ram_wren, 1);
    step();                                  // cycle 4
    chk("t3_done", done, 3'b001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_blocked_gnt", gnt, 0);
      chk("t3_blocked_busy", busy, 0);
    end
    req  = 3'b000;
    hold = 1'b0;

    // Reset in second RD cycle, then same request completes; col 0 val A
    set_req(0, 5'd5, 6'd0, 4'hA);
    req = 3'b001;
    step();                                  // cycle 1
    chk("t4_gnt_c1", gnt, 3'b001);
    step();                                  // cycle 2
    reset = 1'b0;
    #1;
    chk_idle_outputs("t4_abort");
    step();
    chk("t4_nowren", ram_wren, 0);
    chk("t4_nodone", done, 0);
    step();
    chk("t4_mem5_kept", mem[5], {160{1'b1}});
    reset = 1'b1;
    step();                                  // accepted on first edge after release
    chk("t4_gnt_re", gnt, 3'b001);
    req = 3'b000;
    step(); step();
    e = {160{1'b1}};
    e[159:156] = 4'hA;
    chk("t4_wren", ram_wren, 1);
    chk("t4_wdata", ram_wdata, e);
    step();
    chk("t4_done", done, 3'b001);
    chk("t4_old", rd_old, 4'hF);
    step();

    // Round robin from a fresh pointer
    reset = 1'b0;
    step();
    reset = 1'b1;
    set_req(0, 5'd1, 6'd1, 4'h1);
    set_req(1, 5'd2, 6'd2, 4'h2);
    set_req(2, 5'd3, 6'd3, 4'h3);
    req = 3'b111;
    step();  chk("t5_g1", gnt, 3'b001);      // cycle 1
    repeat (4) step(); chk("t5_idle5", gnt, 0);
    step();  chk("t5_g6", gnt, 3'b010);      // cycle 6
    repeat (4) step(); chk("t5_idle10", gnt, 0);
    step();  chk("t5_g11", gnt, 3'b100);     // cycle 11
    repeat (4) step(); chk("t5_idle15", gnt, 0);
    step();  chk("t5_g16", gnt, 3'b001);     // cycle 16
    req = 3'b000;
    for (int i = 0; i < 20 && busy; i++) step();
    chk("t5_drain", busy, 0);
    e = {160{1'b1}};
    e[151:148] = 4'h2;
    chk("t5_mem2", mem[2], e);

    // col 39 on requester 2 over a patterned row
    set_req(2, 5'd29, 6'd39, 4'h3);
    req = 3'b100;
    step();
    chk("t6_gnt", gnt, 3'b100);
    req = 3'b000;
    step(); step();
    e = {40{4'h7}};
    e[3:0] = 4'h3;
    chk("t6_wdata", ram_wdata, e);
    step();
    chk("t6_done", done, 3'b100);
    chk("t6_old", rd_old, 4'h7);
    step();
    chk("t6_mem29", mem[29], e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
